keypad_responder: RTL and testbench
===================================

Name: keypad_responder

Overview:
- Synthesizable model of a 4x4 membrane keypad matrix, acting as the far end of the column-scan/row-sense interface.
- The scanner drives one-hot active-low cols; this block pulls the matching row low while the modelled key contact is closed.
- Press requests are sequenced through a handshake with optional contact bounce.
- Used as the keypad stand-in for board-level self-test and simulation of the scanning logic.

Parameters:
- HOLD_W, 8: width of req_hold, the per-press hold duration in slowclk cycles.
- BOUNCE_CYCLES, 4: length of each bounce phase in cycles; must be at least 1.
- GAP_CYCLES, 4: cycles of guaranteed open contact after each release; must be at least 1.
- LFSR_SEED, 8'hA5: bounce LFSR reset value; must be nonzero.

Ports:
- slowclk  in  1  scan clock.
- reset  in  1  asynchronous, active-high.
- cols  in  4  column drive, active-low.
- rows  out  4  row sense, active-low, idle 4'b1111.
- req_valid  in  1  press request valid.
- req_key  in  4  hex key to press.
- req_hold  in  HOLD_W  hold length in cycles.
- req_ready  out  1  request accepted when high with req_valid.
- busy  out  1  press sequence in progress.
- press_count  out  8  number of presses that reached HOLD.

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock slowclk. All state changes on the posedge of slowclk.
- Key map, given as (column c where cols[c]=0, row r driven by rows[r]=0):
  - c=3: C r3, D r2, E r1, F r0.
  - c=2: 3 r3, 6 r2, 9 r1, B r0.
  - c=1: 2 r3, 5 r2, 8 r1, 0 r0.
  - c=0: 1 r3, 4 r2, 7 r1, A r0.
- rows is combinational from cols and registered state: rows[r_key]=0 when contact=1 and cols[c_key]=0. All other bits are 1. No registered path from cols to rows.
- Wired-AND semantics: multiple cols low still pulls the row if the key's column is among them.
- Reset values: state=IDLE, contact=0, rows=1111, req_ready=1, busy=0, press_count=0, lfsr=LFSR_SEED, latched key=0, latched hold=0.
- FSM states: IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP.
- IDLE: req_ready=1, contact=0. On req_valid, latch req_key and req_hold; req_hold=0 is latched as 1. Go to BOUNCE_IN.
- BOUNCE_IN: lasts BOUNCE_CYCLES cycles; contact=lfsr[0]. Then HOLD.
- HOLD: lasts the latched hold count; contact=1. press_count increments by 1 on entry and wraps 255 to 0. Then BOUNCE_OUT.
- BOUNCE_OUT: lasts BOUNCE_CYCLES cycles; contact=lfsr[0]. Then GAP.
- GAP: lasts GAP_CYCLES cycles; contact=0. Then IDLE.
- Handshake:
  - req_ready=1 only in IDLE.
  - req_valid outside IDLE is ignored, not queued.
  - req_key and req_hold are sampled only at the accept edge.
- busy = (state != IDLE).
- Latency: the next accept is possible 2*BOUNCE_CYCLES + hold + GAP_CYCLES cycles after the accept edge (default 12 + hold).
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shift left with the feedback bit into bit 0. Advances every cycle in every state.
- Reset mid-operation: contact clears asynchronously, so rows=1111 immediately. FSM returns to IDLE; the press is not counted further.
- Phase counter width: clog2 of max(BOUNCE_CYCLES, GAP_CYCLES, 2^HOLD_W - 1) + 1. No wrap inside a phase.

Optional Feature:
- Macro KEYPAD_RESPONDER_BOUNCE_EN.
- Defined: BOUNCE_IN and BOUNCE_OUT present as specified, LFSR instantiated.
- Undefined: both bounce states are removed and the LFSR logic is omitted. Sequence is IDLE, then HOLD (entered on the cycle after the accept), then GAP. Accept-to-ready latency is hold + GAP_CYCLES. LFSR_SEED and BOUNCE_CYCLES are unused.

Test Plan:
- Reset, sweep cols 0111/1011/1101/1110 -> rows=1111 on every cycle; req_ready=1, busy=0, press_count=0.
- Bounce off, req_key=5, req_hold=10 -> 10 HOLD cycles with rows=1011 when cols=1101 and rows=1111 when cols=0111. Then 4 GAP cycles with rows=1111. req_ready returns 14 cycles after accept; press_count=1.
- Bounce off, key A in HOLD: cols=1110 -> rows=1110; cols=0000 -> rows=1110; cols=1101 -> rows=1111. Key C in HOLD: cols=0111 -> rows=0111.
- Bounce on, seed A5, key F, hold 3, cols=0111 -> rows[0] follows the lfsr[0] sequence for 4 cycles, is 0 for 3 cycles, follows lfsr[0] for 4 cycles, then is 1 for 4 cycles. Ready returns 15 cycles after accept.
- req_valid with key 2 while busy -> ignored, no key change. req_hold=0 -> exactly 1 HOLD cycle. 256 presses -> press_count=0.
- Reset pulsed mid-HOLD (key 9, cols=1011) -> rows=1111 asynchronously, busy=0, press_count=0, req_ready=1 after release.

Source files
------------

// File: rtl/keypad_responder.sv
// rtl/keypad_responder.sv - 4x4 membrane keypad model answering a column scan with row pulls.
// Contact bounce and its LFSR are built only with KEYPAD_RESPONDER_BOUNCE_EN defined.
module keypad_responder #(
    parameter int         HOLD_W        = 8,
    parameter int         BOUNCE_CYCLES = 4,
    parameter int         GAP_CYCLES    = 4,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic              slowclk,
    input  logic              reset,
    input  logic [3:0]        cols,
    output logic [3:0]        rows,
    input  logic              req_valid,
    input  logic [3:0]        req_key,
    input  logic [HOLD_W-1:0] req_hold,
    output logic              req_ready,
    output logic              busy,
    output logic [7:0]        press_count
);

    localparam int SHORT_MAX = (BOUNCE_CYCLES > GAP_CYCLES) ? BOUNCE_CYCLES : GAP_CYCLES;
    localparam int HOLD_MAX  = (2 ** HOLD_W) - 1;
    localparam int LEN_MAX   = (SHORT_MAX > HOLD_MAX) ? SHORT_MAX : HOLD_MAX;
    localparam int CNT_W     = $clog2(LEN_MAX + 1);

    if (BOUNCE_CYCLES < 1 || GAP_CYCLES < 1 || LFSR_SEED == 8'h00) begin : g_bad_params
        $error("keypad_responder: BOUNCE_CYCLES/GAP_CYCLES must be >= 1 and LFSR_SEED nonzero");
    end

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        HOLD       = 3'd1,
        GAP        = 3'd2
`ifdef KEYPAD_RESPONDER_BOUNCE_EN
        , BOUNCE_IN  = 3'd3,
        BOUNCE_OUT = 3'd4
`endif
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [3:0]        key_q;
    logic [HOLD_W-1:0] hold_q;
    logic              contact;
    logic [1:0]        key_c;
    logic [1:0]        key_r;

`ifdef KEYPAD_RESPONDER_BOUNCE_EN
    logic [7:0] lfsr;

    // Free-running x^8+x^6+x^5+x^4+1 sequence; bounce contact samples bit 0.
    always_ff @(posedge slowclk or posedge reset) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end
`endif

    always_ff @(posedge slowclk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            key_q       <= 4'h0;
            hold_q      <= '0;
            press_count <= 8'd0;
        end else begin
            state <= state_next;
            // The phase counter restarts on every state change and rests at zero in IDLE.
            if (state_next != state || state == IDLE) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (state == IDLE && req_valid) begin
                key_q  <= req_key;
                hold_q <= (req_hold == '0) ? HOLD_W'(1) : req_hold;
            end
            if (state_next == HOLD && state != HOLD) begin
                press_count <= press_count + 8'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        contact    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
`ifdef KEYPAD_RESPONDER_BOUNCE_EN
                    state_next = BOUNCE_IN;
`else
                    state_next = HOLD;
`endif
                end
            end
`ifdef KEYPAD_RESPONDER_BOUNCE_EN
            BOUNCE_IN: begin
                contact = lfsr[0];
                if (cnt == CNT_W'(BOUNCE_CYCLES - 1)) state_next = HOLD;
            end
            BOUNCE_OUT: begin
                contact = lfsr[0];
                if (cnt == CNT_W'(BOUNCE_CYCLES - 1)) state_next = GAP;
            end
`endif
            HOLD: begin
                contact = 1'b1;
                if (cnt == CNT_W'(hold_q) - CNT_W'(1)) begin
`ifdef KEYPAD_RESPONDER_BOUNCE_EN
                    state_next = BOUNCE_OUT;
`else
                    state_next = GAP;
`endif
                end
            end
            GAP: begin
                if (cnt == CNT_W'(GAP_CYCLES - 1)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Matrix position of the latched key: key_c is the column index, key_r the row index.
    always_comb begin
        key_c = 2'd0;
        key_r = 2'd0;
        case (key_q)
            4'hC: begin key_c = 2'd3; key_r = 2'd3; end
            4'hD: begin key_c = 2'd3; key_r = 2'd2; end
            4'hE: begin key_c = 2'd3; key_r = 2'd1; end
            4'hF: begin key_c = 2'd3; key_r = 2'd0; end
            4'h3: begin key_c = 2'd2; key_r = 2'd3; end
            4'h6: begin key_c = 2'd2; key_r = 2'd2; end
            4'h9: begin key_c = 2'd2; key_r = 2'd1; end
            4'hB: begin key_c = 2'd2; key_r = 2'd0; end
            4'h2: begin key_c = 2'd1; key_r = 2'd3; end
            4'h5: begin key_c = 2'd1; key_r = 2'd2; end
            4'h8: begin key_c = 2'd1; key_r = 2'd1; end
            4'h0: begin key_c = 2'd1; key_r = 2'd0; end
            4'h1: begin key_c = 2'd0; key_r = 2'd3; end
            4'h4: begin key_c = 2'd0; key_r = 2'd2; end
            4'h7: begin key_c = 2'd0; key_r = 2'd1; end
            default: begin key_c = 2'd0; key_r = 2'd0; end
        endcase
    end

    // Pure combinational pull so the scanner sees the row in the same cycle it drives the column.
    always_comb begin
        rows = 4'b1111;
        if (contact && !cols[key_c]) rows[key_r] = 1'b0;
    end

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_keypad_responder.sv
// tb/tb_keypad_responder.sv - directed vector bench for keypad_responder.
module tb_keypad_responder;

`ifdef KEYPAD_RESPONDER_BOUNCE_EN
    localparam int BL = 4;
`else
    localparam int BL = 0;
`endif

    logic       slowclk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] cols = 4'hF;
    logic [3:0] rows;
    logic       req_valid = 1'b0;
    logic [3:0] req_key = 4'h0;
    logic [7:0] req_hold = 8'd0;
    logic       req_ready;
    logic       busy;
    logic [7:0] press_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] key;
        logic [3:0] cols;
        logic [3:0] rows;
    } vec_t;

    vec_t vecs[20];

    keypad_responder dut (
        .slowclk(slowclk),
        .reset(reset),
        .cols(cols),
        .rows(rows),
        .req_valid(req_valid),
        .req_key(req_key),
        .req_hold(req_hold),
        .req_ready(req_ready),
        .busy(busy),
        .press_count(press_count)
    );

    always #5 slowclk = ~slowclk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req_valid = 1'b0;
        @(negedge slowclk);
        @(negedge slowclk);
        reset = 1'b0;
    endtask

    // Leaves the bench at the first negedge after the accept edge.
    task automatic start_press(input logic [3:0] key, input logic [7:0] hold);
        @(negedge slowclk);
        req_valid = 1'b1;
        req_key = key;
        req_hold = hold;
        @(posedge slowclk);
        @(negedge slowclk);
        req_valid = 1'b0;
    endtask

    task automatic wait_ready(input int start_idx, output int lat);
        int idx;
        idx = start_idx;
        while (!req_ready && idx < start_idx + 600) begin
            @(negedge slowclk);
            idx++;
        end
        lat = idx - 1;
        check("ready_seen", 8'(req_ready), 8'd1);
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    initial begin
        int lat;
        vecs[0]  = '{4'hA, 4'b1110, 4'b1110};
        vecs[1]  = '{4'hA, 4'b0000, 4'b1110};
        vecs[2]  = '{4'hA, 4'b1101, 4'b1111};
        vecs[3]  = '{4'hC, 4'b0111, 4'b0111};
        vecs[4]  = '{4'h5, 4'b1101, 4'b1011};
        vecs[5]  = '{4'h5, 4'b0111, 4'b1111};
        vecs[6]  = '{4'hF, 4'b0111, 4'b1110};
        vecs[7]  = '{4'h9, 4'b1011, 4'b1101};
        vecs[8]  = '{4'h0, 4'b1101, 4'b1110};
        vecs[9]  = '{4'hE, 4'b0000, 4'b1101};
        vecs[10] = '{4'h3, 4'b1111, 4'b1111};
        vecs[11] = '{4'h3, 4'b1011, 4'b0111};
        vecs[12] = '{4'h1, 4'b1110, 4'b0111};
        vecs[13] = '{4'h4, 4'b1010, 4'b1011};
        vecs[14] = '{4'h7, 4'b1110, 4'b1101};
        vecs[15] = '{4'hB, 4'b1011, 4'b1110};
        vecs[16] = '{4'hD, 4'b0111, 4'b1011};
        vecs[17] = '{4'h2, 4'b1101, 4'b0111};
        vecs[18] = '{4'h6, 4'b1011, 4'b1011};
        vecs[19] = '{4'h8, 4'b1101, 4'b1101};

        apply_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge slowclk);
            cols = ~(4'b1000 >> i);
            #1 check("idle_rows", 8'(rows), 8'h0F);
        end
        check("reset_ready", 8'(req_ready), 8'd1);
        check("reset_busy", 8'(busy), 8'd0);
        check("reset_count", press_count, 8'd0);

        // Key 5, hold 10, alternating scan columns.
        start_press(4'h5, 8'd10);
        repeat (BL) @(negedge slowclk);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge slowclk);
            cols = (i % 2 == 0) ? 4'b1101 : 4'b0111;
            #1 check("hold5_rows", 8'(rows), (i % 2 == 0) ? 8'h0B : 8'h0F);
            check("hold5_busy", 8'(busy), 8'd1);
        end
        repeat (BL) @(negedge slowclk);
        cols = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            @(negedge slowclk);
            #1 check("gap_rows", 8'(rows), 8'h0F);
            check("gap_ready", 8'(req_ready), 8'd0);
        end
        wait_ready(2 * BL + 14, lat);
        check("latency_h10", 8'(lat), 8'(2 * BL + 14));
        check("count_1", press_count, 8'd1);

        for (int v = 0; v < 20; v++) begin
            start_press(vecs[v].key, 8'd2);
            repeat (BL) @(negedge slowclk);
            cols = vecs[v].cols;
            #1 check($sformatf("vec%0d_rows", v), 8'(rows), 8'(vecs[v].rows));
            wait_ready(1 + BL, lat);
        end
        check("count_21", press_count, 8'd21);

        // Request while busy must neither change the key nor extend the press.
        start_press(4'h5, 8'd10);
        repeat (BL) @(negedge slowclk);
        cols = 4'b1101;
        #1 check("busy_rows0", 8'(rows), 8'h0B);
        @(negedge slowclk);
        req_valid = 1'b1;
        req_key = 4'h2;
        req_hold = 8'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge slowclk);
            #1 check("busy_ignored_rows", 8'(rows), 8'h0B);
        end
        req_valid = 1'b0;
        wait_ready(5 + BL, lat);
        check("busy_latency", 8'(lat), 8'(2 * BL + 14));
        check("count_22", press_count, 8'd22);

        start_press(4'h0, 8'd0);
        repeat (BL) @(negedge slowclk);
        cols = 4'b1101;
        #1 check("hold0_rows", 8'(rows), 8'h0E);
        wait_ready(1 + BL, lat);
        check("hold0_latency", 8'(lat), 8'(2 * BL + 5));

`ifdef KEYPAD_RESPONDER_BOUNCE_EN
        begin
            logic [7:0] l;
            logic       c;
            reset = 1'b1;
            @(negedge slowclk);
            reset = 1'b0;
            req_valid = 1'b1;
            req_key = 4'hF;
            req_hold = 8'd3;
            cols = 4'b0111;
            l = 8'hA5;
            for (int k = 1; k <= 16; k++) begin
                @(negedge slowclk);
                req_valid = 1'b0;
                l = lfsr_next(l);
                if (k <= 4) c = l[0];
                else if (k <= 7) c = 1'b1;
                else if (k <= 11) c = l[0];
                else c = 1'b0;
                #1;
                if (k <= 15) begin
                    check($sformatf("bounce_k%0d_rows", k), 8'(rows), 8'({3'b111, ~c}));
                    check("bounce_ready_low", 8'(req_ready), 8'd0);
                end else begin
                    check("bounce_ready_15", 8'(req_ready), 8'd1);
                end
            end
        end
`endif

        apply_reset();
        for (int n = 1; n <= 256; n++) begin
            start_press(4'(n), 8'd1);
            wait_ready(1, lat);
            if (n == 255) check("count_255", press_count, 8'd255);
        end
        check("count_wrap", press_count, 8'd0);

        start_press(4'h9, 8'd20);
        repeat (BL) @(negedge slowclk);
        cols = 4'b1011;
        #1 check("k9_rows", 8'(rows), 8'h0D);
        check("k9_count", press_count, 8'd1);
        @(negedge slowclk);
        #2 reset = 1'b1;
        #1 check("async_rows", 8'(rows), 8'h0F);
        check("async_busy", 8'(busy), 8'd0);
        check("async_count", press_count, 8'd0);
        @(negedge slowclk);
        reset = 1'b0;
        @(negedge slowclk);
        check("post_reset_ready", 8'(req_ready), 8'd1);
        check("post_reset_rows", 8'(rows), 8'h0F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
